// File: rtl/saddr_mex_sched_pkg.sv
// Shared types for the saddrcalc miss-replay scheduler: FSM states, queued miss
// entries and the page-number split of a virtual address.
package saddr_mex_sched_pkg;

  localparam int ADDR_W       = 44;
  localparam int ATTR_W       = 4;
  localparam int MEX_PAGE_LSB = 13;
  localparam int PAGE_W       = ADDR_W - MEX_PAGE_LSB;

  typedef enum logic [2:0] {
    IDLE, WREQ, WWAIT, HOLD, RPLY, CHECK, FAULT, DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ATTR_W-1:0] attr;
    logic              thread;
  } miss_ent_t;

  function automatic logic [PAGE_W-1:0] page_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:MEX_PAGE_LSB];
  endfunction

endpackage

// File: rtl/saddr_miss_fifo.sv
// Miss queue: DEPTH-entry circular buffer of miss_ent_t with flush. Exposes the
// head and the entry behind it so the scheduler can coalesce same-page replays.
module saddr_miss_fifo
  import saddr_mex_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  miss_ent_t               din,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output miss_ent_t               head,
  output miss_ent_t               head_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  miss_ent_t         mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CW'(1);
    else if (!do_push && do_pop)
      count_nxt = count - CW'(1);
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/saddr_mex_sched.sv
// Miss-replay scheduler for saddrcalc: queues MLB misses, requests a page walk per
// miss, replays the address through the mex port and faults after bounded retries.
module saddr_mex_sched
  import saddr_mex_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                except,
  input  logic                miss_en,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic [ATTR_W-1:0]   miss_attr,
  input  logic                miss_thread,
  output logic                full,
  output logic                drop,
  output logic                walk_req,
  output logic [PAGE_W-1:0]   walk_page,
  output logic                walk_thread,
  input  logic                walk_ack,
  input  logic                walk_done,
  input  logic                walk_fault,
  output logic                bus_hold,
  output logic                mex_en,
  output logic [ADDR_W-1:0]   mex_addr,
  output logic [ATTR_W-1:0]   mex_attr,
  input  logic                mex_hit,
  output logic                rp_fault,
  output logic                rp_fault_thr,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  sched_state_t    state;
  sched_state_t    state_nxt;
  logic [RW-1:0]   retry;
  logic [RW-1:0]   retry_nxt;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic            more;
  logic            same_page;
  miss_ent_t       din;
  miss_ent_t       head;
  miss_ent_t       head_next;
  miss_ent_t       src;
  logic            bus_hold_q;
  logic            mex_en_q;

  assign din  = '{addr: miss_addr, attr: miss_attr, thread: miss_thread};
  assign push = miss_en && !fifo_full && !except;
  assign full = fifo_full;
  assign busy = (state != IDLE) || !fifo_empty;

  // An entry pushed in the same cycle as a pop is not visible via head_next yet,
  // so "more" only counts entries already stored; IDLE picks up the rest.
  assign more      = (count > CW'(1));
  assign same_page = (page_of(head_next.addr) == page_of(head.addr)) &&
                     (head_next.thread == head.thread);

  assign bus_hold = bus_hold_q && !except;
  assign mex_en   = mex_en_q && !except;

  saddr_miss_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (except),
    .din       (din),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head      (head),
    .head_next (head_next)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    pop       = 1'b0;
    if (except) begin
      retry_nxt = '0;
      // A walk already handed to the walker must be drained before reuse.
      if (state == WWAIT || (state == WREQ && walk_ack) || (state == DRAIN && !walk_done))
        state_nxt = DRAIN;
      else
        state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (!fifo_empty) state_nxt = WREQ;
        WREQ:  if (walk_ack) state_nxt = WWAIT;
        WWAIT: if (walk_done) state_nxt = walk_fault ? FAULT : HOLD;
        HOLD:  state_nxt = RPLY;
        RPLY:  state_nxt = CHECK;
        CHECK: begin
          if (mex_hit) begin
            pop       = 1'b1;
            retry_nxt = '0;
            if (more && same_page)
              state_nxt = HOLD;
            else if (more)
              state_nxt = WREQ;
            else
              state_nxt = IDLE;
          end else begin
            retry_nxt = retry + RW'(1);
            state_nxt = (retry_nxt == RW'(MAX_RETRY)) ? FAULT : WREQ;
          end
        end
        FAULT: begin
          pop       = 1'b1;
          retry_nxt = '0;
          state_nxt = more ? WREQ : IDLE;
        end
        DRAIN: if (walk_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    src = pop ? head_next : head;
  end

  // Outputs are registered from the next state, sourced from the entry that will
  // be at the head once this edge's pop has taken effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      retry        <= '0;
      drop         <= 1'b0;
      walk_req     <= 1'b0;
      walk_page    <= '0;
      walk_thread  <= 1'b0;
      bus_hold_q   <= 1'b0;
      mex_en_q     <= 1'b0;
      mex_addr     <= '0;
      mex_attr     <= '0;
      rp_fault     <= 1'b0;
      rp_fault_thr <= 1'b0;
    end else begin
      state        <= state_nxt;
      retry        <= retry_nxt;
      drop         <= miss_en && (fifo_full || except);
      walk_req     <= (state_nxt == WREQ);
      walk_page    <= (state_nxt == WREQ) ? page_of(src.addr) : '0;
      walk_thread  <= (state_nxt == WREQ) ? src.thread : 1'b0;
      bus_hold_q   <= (state_nxt == HOLD) || (state_nxt == RPLY) || (state_nxt == CHECK);
      mex_en_q     <= (state_nxt == RPLY);
      mex_addr     <= (state_nxt == RPLY) ? src.addr : '0;
      mex_attr     <= (state_nxt == RPLY) ? src.attr : '0;
      rp_fault     <= (state_nxt == FAULT);
      rp_fault_thr <= (state_nxt == FAULT) ? head.thread : 1'b0;
    end
  end

endmodule

// File: tb/tb_saddr_mex_sched.sv
// Scoreboard bench for saddr_mex_sched: directed misses push expected walks,
// replays and faults; a monitor pops and compares as the DUT presents them.
module tb_saddr_mex_sched;
  import saddr_mex_sched_pkg::*;

  typedef struct { logic [30:0] page; logic thread; } walk_exp_t;
  typedef struct { logic [43:0] addr; logic [3:0] attr; } mex_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        except;
  logic        miss_en;
  logic [43:0] miss_addr;
  logic [3:0]  miss_attr;
  logic        miss_thread;
  logic        full;
  logic        drop;
  logic        walk_req;
  logic [30:0] walk_page;
  logic        walk_thread;
  logic        walk_ack;
  logic        walk_done;
  logic        walk_fault;
  logic        bus_hold;
  logic        mex_en;
  logic [43:0] mex_addr;
  logic [3:0]  mex_attr;
  logic        mex_hit;
  logic        rp_fault;
  logic        rp_fault_thr;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int mex_cnt  = 0;
  int last_mex = 0;
  int prev_mex = 0;

  logic auto_ack   = 1'b1;
  logic auto_done  = 1'b1;
  logic fault_next = 1'b0;
  logic force_done = 1'b0;

  walk_exp_t exp_walk[$];
  mex_exp_t  exp_mex[$];
  logic      exp_fault[$];

  always #5 clk = ~clk;

  saddr_mex_sched #(.DEPTH(4), .MAX_RETRY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .except       (except),
    .miss_en      (miss_en),
    .miss_addr    (miss_addr),
    .miss_attr    (miss_attr),
    .miss_thread  (miss_thread),
    .full         (full),
    .drop         (drop),
    .walk_req     (walk_req),
    .walk_page    (walk_page),
    .walk_thread  (walk_thread),
    .walk_ack     (walk_ack),
    .walk_done    (walk_done),
    .walk_fault   (walk_fault),
    .bus_hold     (bus_hold),
    .mex_en       (mex_en),
    .mex_addr     (mex_addr),
    .mex_attr     (mex_attr),
    .mex_hit      (mex_hit),
    .rp_fault     (rp_fault),
    .rp_fault_thr (rp_fault_thr),
    .busy         (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [43:0] a, input logic [3:0] at, input logic th);
    miss_en     = 1'b1;
    miss_addr   = a;
    miss_attr   = at;
    miss_thread = th;
    @(posedge clk); #1;
    miss_en     = 1'b0;
  endtask

  task automatic expWalk(input logic [43:0] a, input logic th);
    walk_exp_t w;
    w.page   = 31'(a >> 13);
    w.thread = th;
    exp_walk.push_back(w);
  endtask

  task automatic expMex(input logic [43:0] a, input logic [3:0] at);
    mex_exp_t m;
    m.addr = a;
    m.attr = at;
    exp_mex.push_back(m);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int k = 0;
    while ((busy || exp_walk.size() != 0 || exp_mex.size() != 0 || exp_fault.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_timeout"}, 64'(k >= budget), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Walker model: acks a pending request at once and finishes one cycle later.
  initial begin
    bit hs;
    walk_ack   = 1'b0;
    walk_done  = 1'b0;
    walk_fault = 1'b0;
    forever begin
      @(negedge clk);
      hs = walk_req && walk_ack;
      @(posedge clk); #1;
      walk_done  = (hs && auto_done) || force_done;
      walk_fault = walk_done && fault_next;
      if (walk_fault) fault_next = 1'b0;
      force_done = 1'b0;
      walk_ack   = auto_ack && walk_req;
    end
  end

  // Monitor: every walk handshake, replay strobe and fault pulse must match the
  // next expectation in its queue.
  initial begin
    walk_exp_t w;
    mex_exp_t  m;
    logic      t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (walk_req && walk_ack) begin
          if (exp_walk.size() == 0) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL unexpected_walk: got page 0x%0h, expected no walk", walk_page);
          end else begin
            w = exp_walk.pop_front();
            checkOutput("walk_page", 64'(walk_page), 64'(w.page));
            checkOutput("walk_thread", 64'(walk_thread), 64'(w.thread));
          end
        end
        if (mex_en) begin
          mex_cnt++;
          prev_mex = last_mex;
          last_mex = cycle;
          checkOutput("mex_bus_hold", 64'(bus_hold), 64'd1);
          if (exp_mex.size() == 0) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL unexpected_mex: got addr 0x%0h, expected no replay", mex_addr);
          end else begin
            m = exp_mex.pop_front();
            checkOutput("mex_addr", 64'(mex_addr), 64'(m.addr));
            checkOutput("mex_attr", 64'(mex_attr), 64'(m.attr));
          end
        end
        if (rp_fault) begin
          if (exp_fault.size() == 0) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL unexpected_fault: got thread %0d, expected no fault", rp_fault_thr);
          end else begin
            t = exp_fault.pop_front();
            checkOutput("rp_fault_thr", 64'(rp_fault_thr), 64'(t));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int c0;
    int k;
    rst = 1'b1; except = 1'b0; miss_en = 1'b0; miss_addr = '0;
    miss_attr = '0; miss_thread = 1'b0; mex_hit = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_full", 64'(full), 0);
    checkOutput("rst_drop", 64'(drop), 0);
    checkOutput("rst_walk_req", 64'(walk_req), 0);
    checkOutput("rst_walk_page", 64'(walk_page), 0);
    checkOutput("rst_bus_hold", 64'(bus_hold), 0);
    checkOutput("rst_mex_en", 64'(mex_en), 0);
    checkOutput("rst_mex_addr", 64'(mex_addr), 0);
    checkOutput("rst_rp_fault", 64'(rp_fault), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    rst = 1'b0;
    tick(2);

    // Single miss, immediate walker, hit on replay.
    $display("[TB] test 1: single miss");
    base = mex_cnt;
    expWalk(44'h0000_1234_5678, 1'b0);
    expMex(44'h0000_1234_5678, 4'h9);
    applyStimulus(44'h0000_1234_5678, 4'h9, 1'b0);
    c0 = cycle;
    waitIdle("t1", 40);
    checkOutput("t1_mex_count", 64'(mex_cnt - base), 1);
    checkOutput("t1_latency", 64'(last_mex - c0), 4);
    checkOutput("t1_busy", 64'(busy), 0);
    checkOutput("t1_mex_addr_idle", 64'(mex_addr), 0);

    // Two misses in one page share a single walk.
    $display("[TB] test 2: same-page coalesce");
    base = mex_cnt;
    expWalk(44'h0000_0000_2000, 1'b1);
    expMex(44'h0000_0000_2000, 4'h3);
    expMex(44'h0000_0000_2FF8, 4'h5);
    applyStimulus(44'h0000_0000_2000, 4'h3, 1'b1);
    applyStimulus(44'h0000_0000_2FF8, 4'h5, 1'b1);
    waitIdle("t2", 40);
    checkOutput("t2_mex_count", 64'(mex_cnt - base), 2);
    checkOutput("t2_mex_spacing", 64'(last_mex - prev_mex), 3);

    // Replay never hits: two walks, two replays, then a fault on thread 1.
    $display("[TB] test 3: retry exhaustion");
    base = mex_cnt;
    mex_hit = 1'b0;
    expWalk(44'h0ABC_DEF0_1234, 1'b1);
    expWalk(44'h0ABC_DEF0_1234, 1'b1);
    expMex(44'h0ABC_DEF0_1234, 4'h7);
    expMex(44'h0ABC_DEF0_1234, 4'h7);
    exp_fault.push_back(1'b1);
    applyStimulus(44'h0ABC_DEF0_1234, 4'h7, 1'b1);
    waitIdle("t3", 60);
    checkOutput("t3_mex_count", 64'(mex_cnt - base), 2);
    checkOutput("t3_queue_empty", 64'(dut.u_fifo.count), 0);
    mex_hit = 1'b1;

    // Walker stalls: queue fills after four pushes, fifth is dropped.
    $display("[TB] test 4: full and drop");
    auto_ack = 1'b0;
    tick(2);
    applyStimulus(44'h0000_0001_0000, 4'h1, 1'b0);
    applyStimulus(44'h0000_0002_0000, 4'h2, 1'b0);
    applyStimulus(44'h0000_0003_0000, 4'h3, 1'b0);
    checkOutput("t4_full_at_3", 64'(full), 0);
    applyStimulus(44'h0000_0004_0000, 4'h4, 1'b0);
    checkOutput("t4_full_at_4", 64'(full), 1);
    checkOutput("t4_drop_at_4", 64'(drop), 0);
    applyStimulus(44'h0000_0005_0000, 4'h5, 1'b0);
    checkOutput("t4_drop_at_5", 64'(drop), 1);
    checkOutput("t4_count", 64'(dut.u_fifo.count), 4);
    tick(1);
    checkOutput("t4_drop_pulse", 64'(drop), 0);
    except = 1'b1;
    tick(1);
    except = 1'b0;
    checkOutput("t4_flush_full", 64'(full), 0);
    checkOutput("t4_flush_busy", 64'(busy), 0);

    // Flush while a walk is outstanding: drain it, never replay.
    $display("[TB] test 5: except in WWAIT");
    base = mex_cnt;
    auto_ack = 1'b1;
    auto_done = 1'b0;
    expWalk(44'h0000_00A0_0000, 1'b0);
    applyStimulus(44'h0000_00A0_0000, 4'h1, 1'b0);
    applyStimulus(44'h0000_00B0_0000, 4'h2, 1'b0);
    applyStimulus(44'h0000_00C0_0000, 4'h3, 1'b1);
    k = 0;
    while (dut.state != WWAIT && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5_reach_wwait", 64'(dut.state == WWAIT), 1);
    except = 1'b1;
    tick(1);
    except = 1'b0;
    checkOutput("t5_state_drain", 64'(dut.state), 64'(DRAIN));
    checkOutput("t5_queue_empty", 64'(dut.u_fifo.count), 0);
    checkOutput("t5_walk_req", 64'(walk_req), 0);
    checkOutput("t5_busy_drain", 64'(busy), 1);
    tick(3);
    checkOutput("t5_still_drain", 64'(dut.state), 64'(DRAIN));
    @(negedge clk);
    force_done = 1'b1;
    tick(3);
    checkOutput("t5_state_idle", 64'(dut.state), 64'(IDLE));
    checkOutput("t5_busy_idle", 64'(busy), 0);
    checkOutput("t5_no_mex", 64'(mex_cnt - base), 0);
    auto_done = 1'b1;

    // Walk fault retires the head; the next entry walks and replays normally.
    $display("[TB] test 6: walk fault");
    base = mex_cnt;
    fault_next = 1'b1;
    expWalk(44'h0000_0123_4000, 1'b1);
    exp_fault.push_back(1'b1);
    expWalk(44'h0000_0456_8000, 1'b0);
    expMex(44'h0000_0456_8000, 4'hC);
    applyStimulus(44'h0000_0123_4000, 4'hA, 1'b1);
    applyStimulus(44'h0000_0456_8000, 4'hC, 1'b0);
    waitIdle("t6", 60);
    checkOutput("t6_mex_count", 64'(mex_cnt - base), 1);
    checkOutput("t6_busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
